// File: rtl/aes_pkg.sv
// Shared AES-128 types, key-expansion FSM states and GF(2^8) helpers.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    FETCH,
    WAIT
  } state_t;

  localparam int unsigned AES128_ROUNDS = 10;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four parallel byte S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  word_t din,
  output word_t dout
);

  // S-box table, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key expansion, one round key per valid/ready handshake.
// Define AES_KEY_EXPAND_RCON_INT_EN to generate rcon internally instead of reading rcon memory.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic [3:0]   rcon_addr,
  input  logic [7:0]   rcon_data,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state;
  block_t     key_q;
  logic [3:0] round_q;
  logic [7:0] rcon_byte;
  word_t      w0, w1, w2, w3, w4, w5, w6, w7;
  word_t      sub_rot;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  aes_subword u_subword (
    .din  ({w3[23:0], w3[31:24]}),
    .dout (sub_rot)
  );

  assign w4 = w0 ^ sub_rot ^ {rcon_byte, 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

`ifdef AES_KEY_EXPAND_RCON_INT_EN
  logic [7:0] rcon_q;
  logic       unused_rcon_data;
  assign rcon_byte        = rcon_q;
  assign rcon_addr        = '0;
  assign unused_rcon_data = ^rcon_data;
`else
  assign rcon_byte = rcon_data;
`endif

  assign rk_out   = key_q;
  assign rk_round = round_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_q     <= '0;
      round_q   <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
`ifdef AES_KEY_EXPAND_RCON_INT_EN
      rcon_q    <= 8'h01;
`else
      rcon_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_q     <= key_in;
            round_q   <= '0;
            key_ready <= 1'b0;
            rk_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= OUT;
`ifdef AES_KEY_EXPAND_RCON_INT_EN
            rcon_q    <= 8'h01;
`endif
          end
        end
        OUT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (round_q == LAST_ROUND) begin
              key_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= FETCH;
`ifndef AES_KEY_EXPAND_RCON_INT_EN
              rcon_addr <= round_q;
`endif
            end
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          key_q    <= {w4, w5, w6, w7};
          round_q  <= round_q + 4'd1;
          rk_valid <= 1'b1;
          state    <= OUT;
`ifdef AES_KEY_EXPAND_RCON_INT_EN
          rcon_q   <= xtime(rcon_q);
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: scoreboard of round keys from an independent model.
module tb_aes_key_expand;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid, key_ready, rk_valid, rk_ready, busy;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_round, rcon_addr;
  logic [7:0]   rcon_data = 8'h00;

  logic         key_valid2, key_ready2, rk_valid2, rk_ready2, busy2;
  logic [127:0] key_in2, rk_out2;
  logic [3:0]   rk_round2, rcon_addr2;
  logic [7:0]   rcon_data2 = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic timing_chk = 1'b0;
  logic addr_pending = 1'b0;
  logic [3:0] exp_addr;

  exp_t         sb [$];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got [0:15];
  logic [7:0]   bsbox [256];
  logic [127:0] held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  aes_key_expand u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_round(rk_round), .rcon_addr(rcon_addr), .rcon_data(rcon_data), .busy(busy)
  );

  aes_key_expand #(.NUM_ROUNDS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid2), .key_ready(key_ready2),
    .key_in(key_in2), .rk_valid(rk_valid2), .rk_ready(rk_ready2), .rk_out(rk_out2),
    .rk_round(rk_round2), .rcon_addr(rcon_addr2), .rcon_data(rcon_data2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [3:0] a);
    case (a)
      4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;
      4'd3: return 8'h08;  4'd4: return 8'h10;  4'd5: return 8'h20;
      4'd6: return 8'h40;  4'd7: return 8'h80;  4'd8: return 8'h1b;
      4'd9: return 8'h36;  default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    rcon_data  <= rom(rcon_addr);
    rcon_data2 <= rom(rcon_addr2);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00; x = a; y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int unsigned x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int unsigned y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      bsbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = k;
    rc = 8'h01;
    exp_rk[0] = k;
    for (int unsigned r = 1; r <= 10; r++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {bsbox[t[31:24]], bsbox[t[23:16]], bsbox[t[15:8]], bsbox[t[7:0]]};
      w0 = w0 ^ t ^ {rc, 24'h000000};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      exp_rk[r] = {w0, w1, w2, w3};
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic push_run(input logic [127:0] k);
    exp_t e;
    model(k);
    for (int unsigned r = 0; r <= 10; r++) begin
      e.round = 4'(r);
      e.key   = exp_rk[r];
      sb.push_back(e);
    end
  endtask

  task automatic start(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !key_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", key_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("sb_drained", sb.size(), 0);
  endtask

  // Monitor: handshakes pop the scoreboard; the next cycle must present the FETCH address.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (key_valid && key_ready) acc_cyc = cyc;
      if (addr_pending) begin
        chk("rcon_addr", rcon_addr, exp_addr);
        addr_pending = 1'b0;
      end
      if (rk_valid && rk_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rk_round", rk_round, e.round);
          chk("rk_out", rk_out, e.key);
          got[rk_round] = rk_out;
          if (e.round != 4'd10) begin
            addr_pending = 1'b1;
`ifdef AES_KEY_EXPAND_RCON_INT_EN
            exp_addr = 4'd0;
`else
            exp_addr = e.round;
`endif
          end else if (timing_chk) begin
            chk("final_latency", cyc - acc_cyc, 31);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
    key_valid2 = 1'b0; key_in2 = '0; rk_ready2 = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_rk_valid", rk_valid, 1'b0);
    chk("rst_rk_out", rk_out, 128'h0);
    chk("rst_rk_round", rk_round, 4'd0);
    chk("rst_rcon_addr", rcon_addr, 4'd0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-speed expansion of the reference key.
    push_run(K);
    timing_chk = 1'b1;
    rk_ready = 1'b1;
    start(K);
    chk("acc_rk_valid", rk_valid, 1'b1);
    chk("acc_rk_round", rk_round, 4'd0);
    chk("acc_key_ready", key_ready, 1'b0);
    chk("acc_busy", busy, 1'b1);
    wait_idle();
    chk("vec_round0", got[0], K);
    chk("vec_round1", got[1], R1);
    chk("vec_round10", got[10], R10);

    // Back-pressure for five cycles on round 3.
    timing_chk = 1'b0;
    push_run(K);
    start(K);
    for (int i = 0; i < 50 && !(!rk_valid && rk_round == 4'd2); i++) begin
      @(posedge clk); #1;
    end
    chk("bp_wait_fetch", {rk_valid, rk_round}, {1'b0, 4'd2});
    rk_ready = 1'b0;
    for (int i = 0; i < 10 && !rk_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_wait_valid", rk_valid, 1'b1);
    held = rk_out;
    chk("bp_round", rk_round, 4'd3);
    chk("bp_key", held, exp_rk[3]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_out", rk_out, held);
      chk("bp_hold_round", rk_round, 4'd3);
      chk("bp_hold_valid", rk_valid, 1'b1);
    end
    rk_ready = 1'b1;
    wait_idle();

    // A second key offered mid-expansion must be ignored.
    timing_chk = 1'b1;
    push_run(K);
    start(K);
    for (int i = 0; i < 50 && !(rk_valid && rk_round == 4'd4); i++) begin
      @(posedge clk); #1;
    end
    chk("ignore_wait_round4", {rk_valid, rk_round}, {1'b1, 4'd4});
    key_in = K2;
    key_valid = 1'b1;
    chk("ignore_key_ready", key_ready, 1'b0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in = '0;
    wait_idle();
    chk("ignore_round10", got[10], R10);

    // Reset during WAIT of round 6, then restart with a new key.
    push_run(K);
    start(K);
    for (int i = 0; i < 50 && !(!rk_valid && rk_round == 4'd5); i++) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_wait_fetch", {rk_valid, rk_round}, {1'b0, 4'd5});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_ready", key_ready, 1'b1);
    chk("mid_rst_rk_valid", rk_valid, 1'b0);
    chk("mid_rst_rk_out", rk_out, 128'h0);
    chk("mid_rst_rk_round", rk_round, 4'd0);
    chk("mid_rst_rcon_addr", rcon_addr, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_run(K2);
    start(K2);
    wait_idle();
    chk("restart_round0", got[0], K2);

    // Short configuration: rounds 0..2 only.
    model(K);
    rk_ready2 = 1'b1;
    key_in2 = K;
    key_valid2 = 1'b1;
    @(posedge clk); #1;
    key_valid2 = 1'b0;
    for (int unsigned r = 0; r <= 2; r++) begin
      for (int i = 0; i < 10 && !rk_valid2; i++) begin
        @(posedge clk); #1;
      end
      chk("nr2_valid", rk_valid2, 1'b1);
      chk("nr2_round", rk_round2, 4'(r));
      chk("nr2_key", rk_out2, exp_rk[r]);
      @(posedge clk); #1;
    end
    chk("nr2_key_ready", key_ready2, 1'b1);
    chk("nr2_busy", busy2, 1'b0);
    chk("nr2_rk_valid", rk_valid2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES-128 key-expansion engine that reads the round-constant memory. It accepts a 128-bit cipher key and emits round keys 0..10 one at a time over a valid/ready stream. It drives the address of the external registered rcon memory (1-cycle read latency) and sits between the key-load path and the round datapath.

## Interface
- NUM_ROUNDS, default 10: last round index emitted. Legal range 1..10.
- clk  in  1  rising-edge clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  block idle and able to accept a key.
- key_in  in  128  cipher key; byte 0 is at bits [127:120].
- rk_valid  out  1  round key presented.
- rk_ready  in  1  consumer accepts round key.
- rk_out  out  128  round key; same byte order as key_in.
- rk_round  out  4  index of rk_out, 0..NUM_ROUNDS.
- rcon_addr  out  4  rcon memory address.
- rcon_data  in  8  rcon memory output, valid one cycle after the address is sampled.
- busy  out  1  high from key acceptance until the last round key is handed off.

## Operation
- FSM states: IDLE, OUT, FETCH, WAIT.
- IDLE: key_ready=1. On key_valid&key_ready, register key_in into the key register and set round=0, then go to OUT. key_valid is ignored in every other state.
- OUT: rk_valid=1, rk_out=key register, rk_round=round. rk_out and rk_round stay stable until rk_ready is sampled high.
  - Handshake with round==NUM_ROUNDS: go to IDLE.
  - Handshake otherwise: go to FETCH.
- FETCH: rcon_addr=round. Addresses 0..9 map to 01,02,…,36. Go to WAIT.
- WAIT: rcon_data is valid.
  - Compute w4=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w5=w1^w4, w6=w2^w5, w7=w3^w6, where w0 is bits [127:96].
  - Register {w4,w5,w6,w7} into the key register, increment round, go to OUT.
- rcon_addr holds its last value outside FETCH. It changes only on entry to FETCH.
- All key arithmetic is GF(2)/XOR on 32-bit words. No carries.
- Reset asserted mid-operation: immediately return to IDLE. The partial expansion is discarded with no handshake.

## Timing
- Reset values: key_ready=1 (IDLE), rk_valid=0, rk_out=0, rk_round=0, rcon_addr=0, busy=0. The key register is 0.
- Key accepted at edge N: rk_valid=1 with round 0 in cycle N+1.
- Round-key handshake at edge M: next round key valid in cycle M+3 (FETCH, WAIT, OUT).
- rk_ready held high: full expansion takes 1+10×3 = 31 cycles from accept to final handshake. key_ready returns in the cycle after the last handshake.
- Back-pressure: with rk_ready low, OUT holds indefinitely and nothing advances.
- busy rises the cycle after key acceptance and falls the cycle after the final handshake.

## Configuration
- AES_KEY_EXPAND_RCON_INT_EN defined: the rcon byte is generated internally.
  - It is a register initialised to 01 at key acceptance and updated by xtime (shift left, XOR 1b on carry-out) after each WAIT.
  - rcon_data is ignored and rcon_addr is tied to 0.
  - FSM states and cycle timing are identical to the external path.
- AES_KEY_EXPAND_RCON_INT_EN undefined: the rcon byte is taken from the external memory via rcon_addr/rcon_data as above.

## Structure
- Shared package aes_pkg holds:
  - word/key typedefs (32-bit word, 128-bit block);
  - the FSM state enum;
  - the xtime function;
  - the constant AES128_ROUNDS=10.
- One sub-module, aes_subword: combinational 32-bit SubWord built from four byte S-box lookups. It is instantiated once on RotWord(w3).

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1:
  - round 0 = key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - final handshake 31 cycles after accept.
- Same key with rk_ready low for 5 cycles at round 3: rk_out/rk_round stable throughout, and the remaining sequence is unchanged.
- key_valid pulsed with a different key during round 4: ignored, key_ready=0, and the expansion completes with the original key.
- rst_n asserted during WAIT of round 6: all outputs at reset values in the same cycle. A new key afterwards restarts from round 0.
- rcon_addr trace over a full run: 0..9 presented in successive FETCH states. Repeat the first scenario with AES_KEY_EXPAND_RCON_INT_EN defined and require identical round keys and cycle timing.
- NUM_ROUNDS=2: rounds 0..2 emitted, then IDLE with key_ready=1 and busy=0.
